// File: rtl/uart_tx_slave_pkg.sv
// Shared constants for the UART transmit slave: register offsets, bit indices,
// FSM encoding and the reset baud divider.
package uart_tx_slave_pkg;

    localparam logic [15:0] BAUD_DIV_RST_DEFAULT = 16'd434;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVF   = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Dividers below 2 would collapse a bit to a single cycle or less.
    function automatic logic [15:0] effective_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer. `define UART_TX_FIFO_EN for a DEPTH-entry FIFO;
// otherwise a single holding register stands in for it.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
`else
    logic       valid;
    logic [7:0] hold;

    assign full  = valid;
    assign empty = ~valid;
    assign rdata = hold;
    assign count = CW'(valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            hold  <= '0;
        end else if (push && !valid) begin
            valid <= 1'b1;
            hold  <= wdata;
        end else if (pop && valid) begin
            valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_tx_slave.sv
// UART 8N1 transmitter on an sb slave port with a level TX-drained interrupt.
// Buffer depth is selected by `define UART_TX_FIFO_EN (see uart_tx_fifo).
module uart_tx_slave
    import uart_tx_slave_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int BAUD_DIV_RST = int'(BAUD_DIV_RST_DEFAULT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_sel,
    input  logic [3:0]  s_rw,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    output logic        tx,
    output logic        irq
);

    logic [1:0]  reg_sel;
    logic        wr;
    logic        fifo_push;
    logic        fifo_pop;
    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    logic [15:0] bauddiv;
    logic        enable;
    logic        irq_en;
    logic        overflow;

    logic [1:0]  state;
    logic [15:0] cyc;
    logic [15:0] cur_div;
    logic [7:0]  shreg;
    logic [2:0]  bitn;
    logic        busy;
    logic        bit_done;
    logic        launch;
    logic [3:0]  status_bits;
    logic        unused_bits;

    assign reg_sel   = s_addr[3:2];
    assign wr        = s_sel && (s_rw != 4'b0000);
    assign fifo_push = wr && (reg_sel == REG_TXDATA) && s_rw[0];
    assign busy      = (state != ST_IDLE);
    assign bit_done  = (cyc == 16'd0);
    assign irq       = irq_en & fifo_empty & ~busy;
    assign unused_bits = &{1'b0, s_addr[31:4], s_addr[1:0], s_wdata[31:16], fifo_count};

    // A new frame starts from IDLE or straight out of the last STOP cycle.
    assign launch   = enable && !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));
    assign fifo_pop = launch;

    assign status_bits[STATUS_BUSY]  = busy;
    assign status_bits[STATUS_FULL]  = fifo_full;
    assign status_bits[STATUS_EMPTY] = fifo_empty;
    assign status_bits[STATUS_OVF]   = overflow;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bauddiv  <= 16'(BAUD_DIV_RST);
            enable   <= 1'b1;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr && reg_sel == REG_STATUS && s_rw[0] && s_wdata[STATUS_OVF]) begin
                overflow <= 1'b0;
            end
            if (wr && reg_sel == REG_BAUDDIV) begin
                if (s_rw[0]) bauddiv[7:0]  <= s_wdata[7:0];
                if (s_rw[1]) bauddiv[15:8] <= s_wdata[15:8];
            end
            if (wr && reg_sel == REG_CTRL && s_rw[0]) begin
                enable <= s_wdata[CTRL_EN];
                irq_en <= s_wdata[CTRL_IRQ_EN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_rdata <= '0;
        end else if (s_sel && s_rw == 4'b0000) begin
            case (reg_sel)
                REG_STATUS:  s_rdata <= {28'b0, status_bits};
                REG_BAUDDIV: s_rdata <= {16'b0, bauddiv};
                REG_CTRL:    s_rdata <= {30'b0, irq_en, enable};
                default:     s_rdata <= '0;
            endcase
        end else begin
            s_rdata <= '0;
        end
    end

    // The divider is captured at launch so mid-frame BAUDDIV writes wait for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            cyc     <= '0;
            cur_div <= 16'd2;
            shreg   <= '0;
            bitn    <= '0;
        end else if (launch) begin
            state   <= ST_START;
            tx      <= 1'b0;
            cur_div <= effective_div(bauddiv);
            cyc     <= effective_div(bauddiv) - 16'd1;
            shreg   <= fifo_rdata;
            bitn    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                end
                ST_START: begin
                    if (bit_done) begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        cyc   <= cur_div - 16'd1;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        if (bitn == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            bitn  <= bitn + 3'd1;
                        end
                        cyc <= cur_div - 16'd1;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        state <= ST_IDLE;
                    end else begin
                        cyc <= cyc - 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Bench for uart_tx_slave: a frame-level model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_uart_tx_slave;
    import uart_tx_slave_pkg::*;

    localparam int DEPTH = 8;
`ifdef UART_TX_FIFO_EN
    localparam int MDEPTH = DEPTH;
`else
    localparam int MDEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_sel = 1'b0;
    logic [3:0]  s_rw = 4'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_rdata;
    logic        tx;
    logic        irq;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    uart_tx_slave #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(434)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_sel   (s_sel),
        .s_rw    (s_rw),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Frame-level model: a byte queue plus the frame in flight as a 10-bit
    // pattern indexed by elapsed cycles divided by the latched divider.
    logic [7:0]  mq[$];
    logic        m_ovf, m_en, m_irqen, m_active;
    logic [15:0] m_baud, m_div;
    int          m_t;
    logic [9:0]  m_bits;
    logic [31:0] m_rdata;

    function automatic logic model_tx();
        if (!m_active) return 1'b1;
        return m_bits[m_t / int'(m_div)];
    endfunction

    always @(posedge clk) begin : model
        bit pre_empty, pre_full, frame_end, start;
        logic [15:0] pre_baud;
        logic [7:0] b;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_en = 1'b1; m_irqen = 1'b0; m_active = 1'b0;
            m_baud = 16'd434; m_div = 16'd2; m_t = 0; m_bits = '1; m_rdata = '0;
        end else begin
            pre_empty = (mq.size() == 0);
            pre_full  = (mq.size() == MDEPTH);
            pre_baud  = m_baud;
            m_rdata = '0;
            if (s_sel && s_rw == 4'b0) begin
                case (s_addr[3:2])
                    2'd1: m_rdata = {28'b0, m_ovf, pre_empty, pre_full, m_active};
                    2'd2: m_rdata = {16'b0, m_baud};
                    2'd3: m_rdata = {30'b0, m_irqen, m_en};
                    default: m_rdata = '0;
                endcase
            end
            frame_end = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * int'(m_div)) frame_end = 1'b1;
            end
            start = (!m_active || frame_end) && m_en && !pre_empty;
            if (start) begin
                b = mq.pop_front();
                m_bits = {1'b1, b, 1'b0};
                m_div = (pre_baud < 16'd2) ? 16'd2 : pre_baud;
                m_t = 0;
                m_active = 1'b1;
            end else if (frame_end) begin
                m_active = 1'b0;
            end
            if (s_sel && s_rw != 4'b0) begin
                case (s_addr[3:2])
                    2'd0: if (s_rw[0]) begin
                        if (pre_full) m_ovf = 1'b1;
                        else mq.push_back(s_wdata[7:0]);
                    end
                    2'd1: if (s_rw[0] && s_wdata[3]) m_ovf = 1'b0;
                    2'd2: begin
                        if (s_rw[0]) m_baud[7:0]  = s_wdata[7:0];
                        if (s_rw[1]) m_baud[15:8] = s_wdata[15:8];
                    end
                    default: if (s_rw[0]) begin
                        m_en = s_wdata[0];
                        m_irqen = s_wdata[1];
                    end
                endcase
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic sel, input logic [3:0] rw,
                                 input logic [1:0] reg_idx, input logic [31:0] wdata);
        s_sel   = sel;
        s_rw    = rw;
        s_addr  = {28'h4000_000, reg_idx, 2'b00};
        s_wdata = wdata;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'b0, 2'd0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_tx", 32'(tx), 32'(model_tx()));
            checkOutput("model_irq", 32'(irq), 32'(m_irqen && mq.size() == 0 && !m_active));
            checkOutput("model_rdata", s_rdata, m_rdata);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [9:0] fr;
        bit drained;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        rst = 1'b0;
        checkOutput("reset_tx", 32'(tx), 32'h1);
        checkOutput("reset_irq", 32'(irq), 32'h0);
        checkOutput("reset_rdata", s_rdata, 32'h0);
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("status_after_reset", s_rdata, 32'h4);
        applyStimulus(1'b1, 4'b0, REG_BAUDDIV, 32'h0);
        checkOutput("bauddiv_after_reset", s_rdata, 32'd434);

        // 0xA5 at divider 4; sample mid-bit, busy still set on the 40th cycle.
        applyStimulus(1'b1, 4'b0011, REG_BAUDDIV, 32'd4);
        applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'hA5);
        idleCycle();
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 40; j++) begin
            if (j % 4 == 2) checkOutput($sformatf("a5_bit%0d", j / 4), 32'(tx), 32'(fr[j / 4]));
            if (j == 39) applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
            else idleCycle();
        end
        checkOutput("a5_after_tx", 32'(tx), 32'h1);
        checkOutput("a5_status_last_cycle", s_rdata, 32'h5);
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("a5_status_done", s_rdata, 32'h4);

        // Overfill while disabled, then clear overflow and drain.
        applyStimulus(1'b1, 4'b0001, REG_CTRL, 32'h0);
        for (int k = 0; k <= MDEPTH; k++) applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h10 + k);
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("ovf_status", s_rdata, 32'hA);
        applyStimulus(1'b1, 4'b0001, REG_STATUS, 32'h8);
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("ovf_cleared", s_rdata, 32'h2);
        applyStimulus(1'b1, 4'b0001, REG_CTRL, 32'h1);
        drained = 1'b0;
        for (int k = 0; k < 1000 && !drained; k++) begin
            applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
            if (s_rdata == 32'h4) drained = 1'b1;
        end
        checkOutput("drain_status", s_rdata, 32'h4);

        // Back-to-back frames with irq at the end of the second STOP.
        applyStimulus(1'b1, 4'b0001, REG_CTRL, 32'h3);
        checkOutput("irq_idle_enabled", 32'(irq), 32'h1);
        applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h3C);
        idleCycle();
        for (int j = 0; j <= 80; j++) begin
            if (j == 39) checkOutput("b2b_stop1", 32'(tx), 32'h1);
            if (j == 40) checkOutput("b2b_start2", 32'(tx), 32'h0);
            if (j == 79) checkOutput("b2b_irq_low", 32'(irq), 32'h0);
            if (j == 80) checkOutput("b2b_irq_high", 32'(irq), 32'h1);
            if (j == 0) applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'hC3);
            else idleCycle();
        end
        applyStimulus(1'b1, 4'b0001, REG_CTRL, 32'h1);

        // Divider change mid-frame applies to the following frame only.
        applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h0F);
        idleCycle();
        for (int j = 0; j <= 120; j++) begin
            if (j == 4)   checkOutput("div_f1_bit0", 32'(tx), 32'h1);
            if (j == 24)  checkOutput("div_f1_bit5", 32'(tx), 32'h0);
            if (j == 44)  checkOutput("div_f2_start_wide", 32'(tx), 32'h0);
            if (j == 48)  checkOutput("div_f2_bit0", 32'(tx), 32'h1);
            if (j == 120) checkOutput("div_f2_done", 32'(tx), 32'h1);
            if (j == 0) applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h01);
            else if (j == 10) applyStimulus(1'b1, 4'b0011, REG_BAUDDIV, 32'd8);
            else idleCycle();
        end
        applyStimulus(1'b1, 4'b0, REG_BAUDDIV, 32'h0);
        checkOutput("bauddiv_readback", s_rdata, 32'd8);

        // Reset in the middle of DATA with a byte still queued.
        applyStimulus(1'b1, 4'b0011, REG_BAUDDIV, 32'd4);
        applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h55);
        idleCycle();
        for (int j = 0; j < 12; j++) begin
            if (j == 0) applyStimulus(1'b1, 4'b0001, REG_TXDATA, 32'h66);
            else idleCycle();
        end
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        checkOutput("rst_mid_frame_tx", 32'(tx), 32'h1);
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("rst_mid_frame_status", s_rdata, 32'h4);
        repeat (60) idleCycle();
        applyStimulus(1'b1, 4'b0, REG_STATUS, 32'h0);
        checkOutput("rst_queue_discarded", s_rdata, 32'h4);
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_slave.md
UART_TX_SLAVE -- requirements
Module: uart_tx_slave

Interface
REQ-001 Parameter: FIFO_DEPTH, 8, transmit FIFO entries (power of two, 2..64).
REQ-002 Parameter: BAUD_DIV_RST, 434, reset value of BAUDDIV (50 MHz / 115200).
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  system clock, same domain as sb.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 s_sel  in  1  slave select from sb address decode.
REQ-007 s_rw  in  4  per-byte write enables; 4'b0000 = read.
REQ-008 s_addr  in  32  byte address; only s_addr[3:2] decoded.
REQ-009 s_wdata  in  32  write data.
REQ-010 s_rdata  out  32  registered read data.
REQ-011 tx  out  1  UART serial output, idle high.
REQ-012 irq  out  1  level interrupt, TX-drained.

Function
REQ-013 Register map (s_addr[3:2]): 0 TXDATA (W), 1 STATUS (R/W1C), 2 BAUDDIV (R/W, 16 bit), 3 CTRL (R/W).
REQ-014 A register write occurs in the cycle s_sel=1 and s_rw!=0; only enabled byte lanes update; TXDATA push requires s_rw[0].
REQ-015 s_rdata updates on the clock edge after the address is presented (1-cycle latency, same as dmem); TXDATA and unselected cycles return 0.
REQ-016 STATUS = {28'b0, overflow, empty, full, busy}; writing 1 to bit 3 clears overflow.
REQ-017 CTRL bit0 = enable (reset 1), bit1 = irq_en (reset 0); other bits read 0.
REQ-018 A TXDATA push while full is dropped and sets overflow.
REQ-019 A simultaneous push and pop both take effect; occupancy unchanged.
REQ-020 Frame: 8N1, LSB first; FSM IDLE -> START -> DATA (8 bits) -> STOP -> IDLE.
REQ-021 IDLE -> START when enable=1 and FIFO non-empty; the head entry pops in that cycle.
REQ-022 Each bit lasts exactly BAUDDIV cycles; BAUDDIV < 2 is treated as 2.
REQ-023 BAUDDIV is latched at frame start; mid-frame writes apply to the next frame.
REQ-024 At the end of STOP, the FSM goes directly to START (no idle bit) if enable=1 and the FIFO is non-empty.
REQ-025 Clearing enable mid-frame completes the current frame; no new frame starts.
REQ-026 busy = FSM not IDLE; irq = irq_en & empty & ~busy.
REQ-027 FIFO read/write pointers wrap modulo FIFO_DEPTH; occupancy counter width = clog2(FIFO_DEPTH)+1.

Reset
REQ-028 On rst, regardless of frame progress, the block enters the following state at the next edge:
- tx = 1, FSM = IDLE
- FIFO empty, overflow = 0
- BAUDDIV = BAUD_DIV_RST, CTRL = 2'b01
- s_rdata = 0, irq = 0

Configuration
REQ-029 Macro UART_TX_FIFO_EN selects the transmit buffering.
- Defined: FIFO_DEPTH-entry FIFO as above.
- Undefined: single holding register (depth 1); full = holding valid; FIFO_DEPTH is ignored; all other behaviour is unchanged.

Structure
REQ-030 Register offsets, STATUS/CTRL bit indices, the FSM state encoding and BAUD_DIV_RST go in the shared defines.v.
REQ-031 The FIFO is sub-module uart_tx_fifo (push, pop, data, full, empty, count); the bypass for the undefined UART_TX_FIFO_EN case is inside it.
REQ-032 The block is connected to a new sb slave port; no change to CoNM.

Verification
REQ-033 After reset, read STATUS -> 0x4 on the next cycle; read BAUDDIV -> 434; tx = 1.
REQ-034 BAUDDIV = 4, write TXDATA = 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; busy for 40 cycles.
REQ-035 With the FIFO enabled, 9 TXDATA writes while disabled -> full = 1, overflow = 1; writing STATUS = 0x8 clears overflow.
REQ-036 irq_en = 1, two bytes pushed -> back-to-back frames with no idle gap; irq rises the cycle after the second STOP ends.
REQ-037 Write BAUDDIV = 8 mid-frame at divider 4 -> the current frame keeps 4-cycle bits; the next frame uses 8.
REQ-038 Assert rst during DATA -> tx = 1 and STATUS = 0x4 at the next edge; the queued byte is discarded.
